usb_audio_feature_ctrl: RTL and testbench
=========================================

// Module: usb_audio_feature_ctrl
// PURPOSE
//  Parametrised USB Audio Class 1.0 Feature Unit control handler: services SET_CUR/GET_CUR/GET_MIN/
//  GET_MAX/GET_RES for Mute and Volume on a master channel plus NUM_CHANNELS logical channels.
//  Sits beside the standard-request control FSM on the EP0 OUT/IN stream; the control FSM hands over
//  class requests via Setup_Valid and this block runs the data and status stages.
//  Generalises the fixed 2-channel/8-bit handler: per-channel mute, 16-bit signed dB volume, clamping,
//  change strobes, Length checking.
// PARAMETERS
//  NUM_CHANNELS  2        logical channels (1..8); channel 0 = master
//  UNIT_ID       8'h02    Feature Unit ID matched against wIndex[15:8]
//  INTERFACE     8'h00    AudioControl interface matched against wIndex[7:0]
//  VOL_MIN       16'hC400 signed volume minimum (1/256 dB units, -60 dB)
//  VOL_MAX       16'h0000 signed volume maximum (0 dB)
//  VOL_RES       16'h0100 volume resolution (1 dB)
//  VOL_DEFAULT   16'hF400 reset volume, all channels (-12 dB)
// PORTS
//  Clk             in   1   system clock
//  Reset           in   1   asynchronous, active-high reset
//  Setup_Valid     in   1   1-cycle strobe: class request fields below are valid
//  Setup_Request   in   8   bRequest
//  Setup_Value     in   16  wValue (CS = [15:8], CN = [7:0])
//  Setup_Index     in   16  wIndex (UnitID = [15:8], Interface = [7:0])
//  Setup_Length    in   16  wLength
//  Setup_Dir       in   1   bmRequestType[7] (1 = device-to-host)
//  Busy            out  1   high from accepted Setup_Valid until return to Idle
//  Stall           out  1   request rejected; held until next Setup_Valid
//  OUT_Valid       in   1   OUT byte strobe
//  OUT_EoP         in   1   end of OUT packet (qualified by OUT_Valid)
//  OUT_Data        in   8   OUT byte
//  IN_Data         out  8   IN byte
//  IN_Ready        out  1   IN packet available
//  IN_ZeroLength   out  1   IN packet is zero-length
//  IN_WaitRequest  in   1   low = IN_Data consumed this cycle
//  IN_Ack          in   1   host ACKed the IN packet
//  IN_Sequence     out  1   DATA0/DATA1 toggle for IN
//  Error           in   1   transaction error (no ACK / CRC); retransmit
//  Mute            out  NUM_CHANNELS+1       per-channel mute, bit 0 = master
//  Volume          out  16*(NUM_CHANNELS+1)  signed volumes, [15:0] = master
//  Changed         out  NUM_CHANNELS+1       1-cycle strobe per channel on committed SET_CUR
// BEHAVIOUR
//  Reset: Mute=0, Volume=VOL_DEFAULT all channels, Changed=0, Stall=0, Busy=0, IN_Ready=0,
//   IN_ZeroLength=0, IN_Sequence=0, IN_Data=0, state Idle. Reset mid-transfer aborts with no commit.
//  Setup_Valid in any state: clear Stall, set Busy, IN_Ready=0, IN_Sequence=1, latch fields -> Decode.
//  Decode (1 cycle): valid iff UnitID==UNIT_ID, Interface==INTERFACE, CN<=NUM_CHANNELS, CS in
//   {01 Mute, 02 Volume}, Mute only with CUR; size=1 (Mute) or 2 (Volume).
//   GET_CUR/MIN/MAX/RES (81/82/83/84) need Setup_Dir=1 and Length!=0 -> SendData;
//   SET_CUR (01) needs Setup_Dir=0 and Length==size -> GetData; else Stall=1, Busy=0 -> Idle.
//  SendData: N=min(Length,size); bytes little-endian (Mute = {7'd0,Mute[CN]}); IN_Ready=1,
//   IN_ZeroLength=0; byte advances on each cycle with IN_WaitRequest=0; last byte -> IN_Ready=0,
//   WaitAck. WaitAck: Error -> rewind to byte 0, resend same sequence; IN_Ack -> toggle
//   IN_Sequence -> OutStatus. OutStatus: OUT_Valid&OUT_EoP -> Idle, Busy=0.
//  GetData: shift bytes on OUT_Valid&~OUT_EoP (count saturates at 2); OUT_Valid&OUT_EoP with
//   count!=size -> Stall, Idle, no commit. Count==size -> commit: Mute[CN]<=byte0[0]; Volume
//   clamped to [VOL_MIN,VOL_MAX] signed; Changed[CN]=1 one cycle -> InStatus.
//  InStatus: IN_ZeroLength=1, IN_Ready=1, IN_Sequence=1; IN_Ack -> IN_Ready=0, Busy=0, Idle;
//   Error -> stay, IN_Ready held.
//  Setup_Valid same cycle as IN_Ack/OUT_EoP: Setup_Valid wins; pending commit discarded.
//  Volume value 16'h8000 (-inf) on SET is clamped to VOL_MIN.
// TESTING
//  GET_CUR Volume CN=1, Length=2 after reset -> IN bytes 00,F4; IN_Sequence 1 then 0 after Ack.
//  SET_CUR Volume CN=2 data 00,10 (+16 dB) -> Volume[47:32]=0000 (clamped), Changed=3'b100 one cycle.
//  SET_CUR Mute CN=0 data 01 -> Mute=3'b001, zero-length IN status, Busy low after IN_Ack.
//  GET_MIN CN=1, Length=1 -> single byte 00; Error in WaitAck -> byte 00 resent, same sequence.
//  GET_MIN Mute, or CN=3 with NUM_CHANNELS=2, or UnitID=05 -> Stall=1, no IN_Ready.
//  SET_CUR Volume with 1-byte data stage -> Stall=1, Volume unchanged, Changed stays 0.

Source files
------------

// File: rtl/usb_audio_feature_ctrl.sv
// USB Audio Class 1.0 Feature Unit handler: Mute/Volume SET_CUR and GET_CUR/MIN/MAX/RES
// on a master channel plus NUM_CHANNELS logical channels, running the EP0 data/status stages.
module usb_audio_feature_ctrl #(
  parameter int unsigned        NUM_CHANNELS = 2,
  parameter logic [7:0]         UNIT_ID      = 8'h02,
  parameter logic [7:0]         INTERFACE    = 8'h00,
  parameter logic signed [15:0] VOL_MIN      = 16'hC400,
  parameter logic signed [15:0] VOL_MAX      = 16'h0000,
  parameter logic [15:0]        VOL_RES      = 16'h0100,
  parameter logic [15:0]        VOL_DEFAULT  = 16'hF400
) (
  input  logic                             Clk,
  input  logic                             Reset,
  input  logic                             Setup_Valid,
  input  logic [7:0]                       Setup_Request,
  input  logic [15:0]                      Setup_Value,
  input  logic [15:0]                      Setup_Index,
  input  logic [15:0]                      Setup_Length,
  input  logic                             Setup_Dir,
  output logic                             Busy,
  output logic                             Stall,
  input  logic                             OUT_Valid,
  input  logic                             OUT_EoP,
  input  logic [7:0]                       OUT_Data,
  output logic [7:0]                       IN_Data,
  output logic                             IN_Ready,
  output logic                             IN_ZeroLength,
  input  logic                             IN_WaitRequest,
  input  logic                             IN_Ack,
  output logic                             IN_Sequence,
  input  logic                             Error,
  output logic [NUM_CHANNELS:0]            Mute,
  output logic [16*(NUM_CHANNELS+1)-1:0]   Volume,
  output logic [NUM_CHANNELS:0]            Changed
);

  localparam int unsigned NumCh = NUM_CHANNELS + 1;
  localparam int unsigned ChW   = $clog2(NumCh);
  localparam logic [7:0]  MaxCn = 8'(NUM_CHANNELS);

  typedef enum logic [2:0] {
    StIdle, StDecode, StSendData, StWaitAck, StOutStatus, StGetData, StInStatus
  } state_e;

  state_e                     state_q, state_d;
  logic                       stall_q, stall_d;
  logic                       seq_q, seq_d;
  logic [7:0]                 req_q, req_d;
  logic [7:0]                 cs_q, cs_d;
  logic [7:0]                 cn_q, cn_d;
  logic [15:0]                idx_q, idx_d;
  logic [15:0]                len_q, len_d;
  logic                       dir_q, dir_d;
  logic [15:0]                tx_q, tx_d;
  logic                       last_q, last_d;
  logic                       pos_q, pos_d;
  logic [15:0]                rx_q, rx_d;
  logic [1:0]                 cnt_q, cnt_d;
  logic [NumCh-1:0]           mute_q, mute_d;
  logic [NumCh-1:0][15:0]     vol_q, vol_d;
  logic [NumCh-1:0]           changed_q, changed_d;

  logic [ChW-1:0]     cn_sel;
  logic               is_mute, is_vol, addr_ok, is_get, get_ok, set_ok;
  logic [1:0]         size;
  logic [15:0]        cur_val;
  logic signed [15:0] rx_s;
  logic [15:0]        vol_clamped;

  always_comb begin
    cn_sel  = cn_q[ChW-1:0];
    is_mute = (cs_q == 8'h01);
    is_vol  = (cs_q == 8'h02);
    size    = is_vol ? 2'd2 : 2'd1;
    addr_ok = (idx_q[15:8] == UNIT_ID) && (idx_q[7:0] == INTERFACE) && (cn_q <= MaxCn) &&
              (is_mute || is_vol);
    is_get  = (req_q == 8'h81) || (req_q == 8'h82) || (req_q == 8'h83) || (req_q == 8'h84);
    // Mute only has a CUR attribute.
    get_ok  = is_get && dir_q && (len_q != 16'd0) && (is_vol || req_q == 8'h81);
    set_ok  = (req_q == 8'h01) && !dir_q && (len_q == {14'd0, size});
    cur_val = is_mute ? {15'd0, mute_q[cn_sel]} : vol_q[cn_sel];
    rx_s    = rx_q;
    if (rx_s < VOL_MIN)      vol_clamped = VOL_MIN;
    else if (rx_s > VOL_MAX) vol_clamped = VOL_MAX;
    else                     vol_clamped = rx_q;
  end

  always_comb begin
    state_d   = state_q;
    stall_d   = stall_q;
    seq_d     = seq_q;
    req_d     = req_q;
    cs_d      = cs_q;
    cn_d      = cn_q;
    idx_d     = idx_q;
    len_d     = len_q;
    dir_d     = dir_q;
    tx_d      = tx_q;
    last_d    = last_q;
    pos_d     = pos_q;
    rx_d      = rx_q;
    cnt_d     = cnt_q;
    mute_d    = mute_q;
    vol_d     = vol_q;
    changed_d = '0;

    case (state_q)
      StIdle: ;
      StDecode: begin
        if (addr_ok && get_ok) begin
          case (req_q)
            8'h82:   tx_d = VOL_MIN;
            8'h83:   tx_d = VOL_MAX;
            8'h84:   tx_d = VOL_RES;
            default: tx_d = cur_val;
          endcase
          last_d  = is_vol && (len_q != 16'd1);
          pos_d   = 1'b0;
          state_d = StSendData;
        end else if (addr_ok && set_ok) begin
          cnt_d   = 2'd0;
          rx_d    = 16'd0;
          state_d = StGetData;
        end else begin
          stall_d = 1'b1;
          state_d = StIdle;
        end
      end
      StSendData: begin
        if (!IN_WaitRequest) begin
          if (pos_q == last_q) begin
            pos_d   = 1'b0;
            state_d = StWaitAck;
          end else begin
            pos_d = 1'b1;
          end
        end
      end
      StWaitAck: begin
        if (Error) begin
          pos_d   = 1'b0;
          state_d = StSendData;
        end else if (IN_Ack) begin
          seq_d   = ~seq_q;
          state_d = StOutStatus;
        end
      end
      StOutStatus: begin
        if (OUT_Valid && OUT_EoP) state_d = StIdle;
      end
      StGetData: begin
        if (OUT_Valid && OUT_EoP) begin
          if (cnt_q == size) begin
            if (is_mute) mute_d[cn_sel] = rx_q[0];
            else         vol_d[cn_sel]  = vol_clamped;
            changed_d[cn_sel] = 1'b1;
            seq_d   = 1'b1;
            state_d = StInStatus;
          end else begin
            stall_d = 1'b1;
            state_d = StIdle;
          end
        end else if (OUT_Valid) begin
          if (cnt_q == 2'd0)      rx_d[7:0]  = OUT_Data;
          else if (cnt_q == 2'd1) rx_d[15:8] = OUT_Data;
          if (cnt_q != 2'd2) cnt_d = cnt_q + 2'd1;
        end
      end
      StInStatus: begin
        if (IN_Ack) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new setup overrides everything, including a commit landing this cycle.
    if (Setup_Valid) begin
      state_d   = StDecode;
      stall_d   = 1'b0;
      seq_d     = 1'b1;
      req_d     = Setup_Request;
      cs_d      = Setup_Value[15:8];
      cn_d      = Setup_Value[7:0];
      idx_d     = Setup_Index;
      len_d     = Setup_Length;
      dir_d     = Setup_Dir;
      mute_d    = mute_q;
      vol_d     = vol_q;
      changed_d = '0;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= StIdle;
      stall_q   <= 1'b0;
      seq_q     <= 1'b0;
      req_q     <= 8'd0;
      cs_q      <= 8'd0;
      cn_q      <= 8'd0;
      idx_q     <= 16'd0;
      len_q     <= 16'd0;
      dir_q     <= 1'b0;
      tx_q      <= 16'd0;
      last_q    <= 1'b0;
      pos_q     <= 1'b0;
      rx_q      <= 16'd0;
      cnt_q     <= 2'd0;
      mute_q    <= '0;
      vol_q     <= {NumCh{VOL_DEFAULT}};
      changed_q <= '0;
    end else begin
      state_q   <= state_d;
      stall_q   <= stall_d;
      seq_q     <= seq_d;
      req_q     <= req_d;
      cs_q      <= cs_d;
      cn_q      <= cn_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      dir_q     <= dir_d;
      tx_q      <= tx_d;
      last_q    <= last_d;
      pos_q     <= pos_d;
      rx_q      <= rx_d;
      cnt_q     <= cnt_d;
      mute_q    <= mute_d;
      vol_q     <= vol_d;
      changed_q <= changed_d;
    end
  end

  assign Busy          = (state_q != StIdle);
  assign Stall         = stall_q;
  assign IN_Ready      = (state_q == StSendData) || (state_q == StInStatus);
  assign IN_ZeroLength = (state_q == StInStatus);
  assign IN_Data       = (state_q == StSendData) ? (pos_q ? tx_q[15:8] : tx_q[7:0]) : 8'h00;
  assign IN_Sequence   = seq_q;
  assign Mute          = mute_q;
  assign Volume        = vol_q;
  assign Changed       = changed_q;

endmodule

// File: tb/tb_usb_audio_feature_ctrl.sv
// Directed table-driven bench for usb_audio_feature_ctrl (NUM_CHANNELS = 2).
module tb_usb_audio_feature_ctrl;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        Setup_Valid;
  logic [7:0]  Setup_Request;
  logic [15:0] Setup_Value, Setup_Index, Setup_Length;
  logic        Setup_Dir;
  logic        Busy, Stall;
  logic        OUT_Valid, OUT_EoP;
  logic [7:0]  OUT_Data;
  logic [7:0]  IN_Data;
  logic        IN_Ready, IN_ZeroLength, IN_WaitRequest, IN_Ack, IN_Sequence, Error;
  logic [2:0]  Mute, Changed;
  logic [47:0] Volume;

  int n_checks = 0;
  int n_fail   = 0;

  usb_audio_feature_ctrl #(
    .NUM_CHANNELS(2), .UNIT_ID(8'h02), .INTERFACE(8'h00), .VOL_MIN(16'hC400),
    .VOL_MAX(16'h0000), .VOL_RES(16'h0100), .VOL_DEFAULT(16'hF400)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Setup_Valid(Setup_Valid), .Setup_Request(Setup_Request),
    .Setup_Value(Setup_Value), .Setup_Index(Setup_Index), .Setup_Length(Setup_Length),
    .Setup_Dir(Setup_Dir), .Busy(Busy), .Stall(Stall), .OUT_Valid(OUT_Valid),
    .OUT_EoP(OUT_EoP), .OUT_Data(OUT_Data), .IN_Data(IN_Data), .IN_Ready(IN_Ready),
    .IN_ZeroLength(IN_ZeroLength), .IN_WaitRequest(IN_WaitRequest), .IN_Ack(IN_Ack),
    .IN_Sequence(IN_Sequence), .Error(Error), .Mute(Mute), .Volume(Volume), .Changed(Changed)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [7:0]  req;
    logic [15:0] val;
    logic [15:0] idx;
    logic [15:0] len;
    logic        dir;
    logic [1:0]  nout;
    logic [15:0] odata;
    logic        stall;
    logic        dstall;
    logic [2:0]  nin;
    logic [15:0] indata;
    logic [2:0]  mute;
    logic [47:0] vol;
    logic [2:0]  chg;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic setup(input logic [7:0] req, input logic [15:0] val, input logic [15:0] idx,
                       input logic [15:0] len, input logic dir);
    Setup_Request = req;
    Setup_Value   = val;
    Setup_Index   = idx;
    Setup_Length  = len;
    Setup_Dir     = dir;
    Setup_Valid   = 1'b1;
  endtask

  // Consume IN bytes while IN_Ready, bounded to 4 bytes.
  task automatic read_in(output logic [31:0] got, output int n);
    got = '0;
    n   = 0;
    while (IN_Ready && n < 4) begin
      got = got | (32'(IN_Data) << (8 * n));
      IN_WaitRequest = 1'b0;
      @(negedge Clk);
      n++;
    end
    IN_WaitRequest = 1'b1;
  endtask

  task automatic out_status();
    OUT_Valid = 1'b1;
    OUT_EoP   = 1'b1;
    @(negedge Clk);
    OUT_Valid = 1'b0;
    OUT_EoP   = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int id);
    logic [31:0] got;
    int          n;
    @(negedge Clk);
    setup(v.req, v.val, v.idx, v.len, v.dir);
    @(negedge Clk);
    Setup_Valid = 1'b0;
    chk($sformatf("v%0d busy_decode", id), Busy, 1);
    @(negedge Clk);
    chk($sformatf("v%0d stall", id), Stall, v.stall);
    if (v.stall) begin
      chk($sformatf("v%0d in_ready", id), IN_Ready, 0);
      chk($sformatf("v%0d busy_stall", id), Busy, 0);
    end else if (v.dir) begin
      read_in(got, n);
      chk($sformatf("v%0d nbytes", id), n, v.nin);
      chk($sformatf("v%0d in_data", id), got, v.indata);
      chk($sformatf("v%0d seq_before", id), IN_Sequence, 1);
      IN_Ack = 1'b1;
      @(negedge Clk);
      IN_Ack = 1'b0;
      chk($sformatf("v%0d seq_after", id), IN_Sequence, 0);
      out_status();
      chk($sformatf("v%0d busy_end", id), Busy, 0);
    end else begin
      for (int i = 0; i < int'(v.nout); i++) begin
        OUT_Valid = 1'b1;
        OUT_Data  = v.odata[8*i +: 8];
        @(negedge Clk);
      end
      out_status();
      chk($sformatf("v%0d changed", id), Changed, v.chg);
      if (v.dstall) begin
        chk($sformatf("v%0d data_stall", id), Stall, 1);
        chk($sformatf("v%0d busy_dstall", id), Busy, 0);
      end else begin
        chk($sformatf("v%0d zlp", id), {IN_Ready, IN_ZeroLength, IN_Sequence}, 3'b111);
        IN_Ack = 1'b1;
        @(negedge Clk);
        IN_Ack = 1'b0;
        chk($sformatf("v%0d changed_clr", id), Changed, 0);
        chk($sformatf("v%0d busy_end", id), Busy, 0);
      end
    end
    chk($sformatf("v%0d mute", id), Mute, v.mute);
    chk($sformatf("v%0d volume", id), Volume, v.vol);
  endtask

  initial begin
    logic [31:0] got;
    int          n;

    //          req    val      idx      len   dir nout odata   st dst nin indata  mute  vol                  chg
    vecs[0]  = '{8'h81, 16'h0201, 16'h0200, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 16'hF400, 3'b000, 48'hF400_F400_F400, 3'b000};
    vecs[1]  = '{8'h01, 16'h0202, 16'h0200, 16'd2,  1'b0, 2'd2, 16'h1000, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b000, 48'h0000_F400_F400, 3'b100};
    vecs[2]  = '{8'h01, 16'h0100, 16'h0200, 16'd1,  1'b0, 2'd1, 16'h0001, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b001};
    vecs[3]  = '{8'h82, 16'h0201, 16'h0200, 16'd1,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd1, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[4]  = '{8'h82, 16'h0100, 16'h0200, 16'd1,  1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[5]  = '{8'h81, 16'h0203, 16'h0200, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[6]  = '{8'h81, 16'h0201, 16'h0500, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[7]  = '{8'h01, 16'h0201, 16'h0200, 16'd2,  1'b0, 2'd1, 16'h0010, 1'b0, 1'b1, 3'd0, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[8]  = '{8'h81, 16'h0100, 16'h0200, 16'd8,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd1, 16'h0001, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[9]  = '{8'h83, 16'h0200, 16'h0200, 16'd64, 1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 16'h0000, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[10] = '{8'h84, 16'h0202, 16'h0200, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 16'h0100, 3'b001, 48'h0000_F400_F400, 3'b000};
    vecs[11] = '{8'h01, 16'h0201, 16'h0200, 16'd2,  1'b0, 2'd2, 16'h8000, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_C400_F400, 3'b010};
    vecs[12] = '{8'h81, 16'h0201, 16'h0200, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd2, 16'hC400, 3'b001, 48'h0000_C400_F400, 3'b000};
    vecs[13] = '{8'h01, 16'h0200, 16'h0200, 16'd2,  1'b0, 2'd2, 16'hEC00, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_C400_EC00, 3'b001};
    vecs[14] = '{8'h81, 16'h0202, 16'h0200, 16'd2,  1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_C400_EC00, 3'b000};
    vecs[15] = '{8'h01, 16'h0200, 16'h0200, 16'd1,  1'b0, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b001, 48'h0000_C400_EC00, 3'b000};
    vecs[16] = '{8'h01, 16'h0102, 16'h0200, 16'd1,  1'b0, 2'd1, 16'h0001, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b101, 48'h0000_C400_EC00, 3'b100};
    vecs[17] = '{8'h81, 16'h0200, 16'h0200, 16'd0,  1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b101, 48'h0000_C400_EC00, 3'b000};
    vecs[18] = '{8'h01, 16'h0202, 16'h0200, 16'd2,  1'b0, 2'd2, 16'hF000, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b101, 48'hF000_C400_EC00, 3'b100};
    vecs[19] = '{8'h81, 16'h0102, 16'h0200, 16'd1,  1'b1, 2'd0, 16'h0000, 1'b0, 1'b0, 3'd1, 16'h0001, 3'b101, 48'hF000_C400_EC00, 3'b000};
    vecs[20] = '{8'h01, 16'h0100, 16'h0200, 16'd1,  1'b0, 2'd1, 16'h00FE, 1'b0, 1'b0, 3'd0, 16'h0000, 3'b100, 48'hF000_C400_EC00, 3'b001};
    vecs[21] = '{8'h81, 16'h0201, 16'h0201, 16'd2,  1'b1, 2'd0, 16'h0000, 1'b1, 1'b0, 3'd0, 16'h0000, 3'b100, 48'hF000_C400_EC00, 3'b000};

    Reset = 1'b1;
    Setup_Valid = 1'b0; Setup_Request = '0; Setup_Value = '0; Setup_Index = '0;
    Setup_Length = '0; Setup_Dir = 1'b0;
    OUT_Valid = 1'b0; OUT_EoP = 1'b0; OUT_Data = '0;
    IN_WaitRequest = 1'b1; IN_Ack = 1'b0; Error = 1'b0;
    repeat (3) @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);

    chk("rst mute", Mute, 3'b000);
    chk("rst volume", Volume, 48'hF400_F400_F400);
    chk("rst changed", Changed, 3'b000);
    chk("rst stall_busy", {Stall, Busy}, 2'b00);
    chk("rst in_flags", {IN_Ready, IN_ZeroLength, IN_Sequence}, 3'b000);
    chk("rst in_data", IN_Data, 8'h00);

    for (int i = 0; i < 22; i++) run_vec(vecs[i], i);

    // Error in WaitAck rewinds to byte 0 with the same sequence bit.
    @(negedge Clk);
    setup(8'h84, 16'h0201, 16'h0200, 16'd2, 1'b1);
    @(negedge Clk);
    Setup_Valid = 1'b0;
    @(negedge Clk);
    read_in(got, n);
    chk("err first data", got, 32'h0100);
    Error = 1'b1;
    @(negedge Clk);
    Error = 1'b0;
    chk("err resend ready_seq", {IN_Ready, IN_Sequence}, 2'b11);
    read_in(got, n);
    chk("err resend data", got, 32'h0100);
    chk("err resend count", n, 2);
    IN_Ack = 1'b1;
    @(negedge Clk);
    IN_Ack = 1'b0;
    chk("err seq toggled", IN_Sequence, 0);
    out_status();
    chk("err busy_end", Busy, 0);

    // Setup_Valid on the commit cycle discards the pending SET_CUR.
    @(negedge Clk);
    setup(8'h01, 16'h0200, 16'h0200, 16'd2, 1'b0);
    @(negedge Clk);
    Setup_Valid = 1'b0;
    @(negedge Clk);
    OUT_Valid = 1'b1;
    OUT_Data  = 8'h00;
    @(negedge Clk);
    @(negedge Clk);
    OUT_EoP = 1'b1;
    setup(8'h81, 16'h0200, 16'h0200, 16'd2, 1'b1);
    @(negedge Clk);
    OUT_Valid = 1'b0; OUT_EoP = 1'b0; Setup_Valid = 1'b0;
    chk("ovr changed", Changed, 3'b000);
    @(negedge Clk);
    read_in(got, n);
    chk("ovr readback", got, 32'hEC00);
    IN_Ack = 1'b1;
    @(negedge Clk);
    IN_Ack = 1'b0;
    out_status();
    chk("ovr volume", Volume, 48'hF000_C400_EC00);

    // Error during the IN status stage keeps the zero-length packet pending.
    @(negedge Clk);
    setup(8'h01, 16'h0101, 16'h0200, 16'd1, 1'b0);
    @(negedge Clk);
    Setup_Valid = 1'b0;
    @(negedge Clk);
    OUT_Valid = 1'b1;
    OUT_Data  = 8'h01;
    @(negedge Clk);
    out_status();
    chk("ist changed", Changed, 3'b010);
    Error = 1'b1;
    @(negedge Clk);
    Error = 1'b0;
    chk("ist held", {IN_Ready, IN_ZeroLength, Busy}, 3'b111);
    IN_Ack = 1'b1;
    @(negedge Clk);
    IN_Ack = 1'b0;
    chk("ist done", {IN_Ready, Busy}, 2'b00);
    chk("ist mute", Mute, 3'b110);

    // Reset mid-transfer: no commit, everything back to defaults.
    @(negedge Clk);
    setup(8'h01, 16'h0202, 16'h0200, 16'd2, 1'b0);
    @(negedge Clk);
    Setup_Valid = 1'b0;
    @(negedge Clk);
    OUT_Valid = 1'b1;
    OUT_Data  = 8'h00;
    @(negedge Clk);
    OUT_Valid = 1'b0;
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    chk("mid rst busy", Busy, 0);
    chk("mid rst volume", Volume, 48'hF400_F400_F400);
    chk("mid rst mute_changed", {Mute, Changed}, 6'b000000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
